// File: rtl/spi_byte_engine_if.sv
// spi_byte_engine_if
//   Bundles the command, bit-bang, SPI pin and status signals of the SPI byte
//   engine.
//   slave  : engine side. Takes CMD_*, BB_* and MISO; drives SCK, MOSI, nSS,
//            BUSY, DONE, RXDATA and OVR.
//   master : controller / bench side, with the opposite directions.
interface spi_byte_engine_if;
  logic       CMD_STB;
  logic [7:0] CMD_DATA;
  logic [1:0] CMD_NSS;
  logic       CMD_CPOL;
  logic       BB_WR;
  logic       BB_SCK;
  logic       BB_MOSI;
  logic [1:0] BB_NSS;
  logic [2:0] MISO;
  logic       SCK;
  logic       MOSI;
  logic [1:0] nSS;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RXDATA;
  logic       OVR;

  modport slave (
    input  CMD_STB, CMD_DATA, CMD_NSS, CMD_CPOL,
    input  BB_WR, BB_SCK, BB_MOSI, BB_NSS, MISO,
    output SCK, MOSI, nSS, BUSY, DONE, RXDATA, OVR
  );

  modport master (
    output CMD_STB, CMD_DATA, CMD_NSS, CMD_CPOL,
    output BB_WR, BB_SCK, BB_MOSI, BB_NSS, MISO,
    input  SCK, MOSI, nSS, BUSY, DONE, RXDATA, OVR
  );
endinterface

// File: rtl/spi_byte_engine.sv
// spi_byte_engine
//   Hardware SPI byte shifter for the expansion port. It performs an 8-bit,
//   MSB-first, full-duplex transfer with CPHA=0 and a per-transfer CPOL. It
//   also arbitrates pin ownership against bit-bang writes.
//   Ports:
//     CLK  - system clock
//     RST  - asynchronous reset, active-high
//     bus  - spi_byte_engine_if.slave:
//              command strobe and fields, bit-bang write, MISO[2:0] in;
//              SCK, MOSI, nSS, BUSY, DONE, RXDATA and sticky OVR out.
//   Parameter CLKDIV: SCK half-period in CLK cycles (1..255).
//
//   state | meaning
//   IDLE  | pins owned by bit-bang writes, waiting for CMD_STB
//   SETUP | MOSI holds the first bit before the first SCK edge
//   LEAD  | SCK at !CPOL; MISO was sampled on entry
//   TRAIL | SCK at CPOL; next MOSI bit was driven on entry
//   FIN   | one-cycle completion: DONE high, RXDATA updated on entry
module spi_byte_engine #(
  parameter int CLKDIV = 2
) (
  input  logic             CLK,
  input  logic             RST,
  spi_byte_engine_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SETUP, LEAD, TRAIL, FIN} state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLKDIV - 1);

  state_t     state, state_nxt;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic       last_bit;
  logic [7:0] shreg;
  logic       cpol;
  logic       sck, mosi;
  logic [1:0] nss;
  logic [7:0] rxdata;
  logic       ovr;
  logic       tc;
  logic       miso_sel;
  logic       enter_lead, enter_trail;

  assign tc = (div_cnt == 8'd0);

  // The active slave's line is picked using the selects currently on the pins.
  // MISO[2] is the line used when no slave is selected.
  assign miso_sel = (bus.MISO[0] & ~nss[0]) |
                    (bus.MISO[1] & ~nss[1]) |
                    (bus.MISO[2] &  nss[0] & nss[1]);

  assign enter_lead  = (state_nxt == LEAD)  && (state != LEAD);
  assign enter_trail = (state_nxt == TRAIL) && (state != TRAIL);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.CMD_STB) state_nxt = SETUP;
      SETUP:   if (tc) state_nxt = LEAD;
      LEAD:    if (tc) state_nxt = TRAIL;
      TRAIL:   if (tc) state_nxt = last_bit ? FIN : LEAD;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.BUSY = (state != IDLE);
    bus.DONE = (state == FIN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt  <= 8'd0;
      bit_cnt  <= 3'd0;
      last_bit <= 1'b0;
      shreg    <= 8'd0;
      cpol     <= 1'b0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      nss      <= 2'b11;
      rxdata   <= 8'd0;
      ovr      <= 1'b0;
    end else begin
      // Every state is held for CLKDIV cycles, so reload on each state change.
      if (state != state_nxt)  div_cnt <= DIV_LOAD;
      else if (!tc)            div_cnt <= div_cnt - 8'd1;

      if (state == IDLE) begin
        if (bus.CMD_STB) begin
          shreg    <= bus.CMD_DATA;
          cpol     <= bus.CMD_CPOL;
          nss      <= bus.CMD_NSS;
          sck      <= bus.CMD_CPOL;
          mosi     <= bus.CMD_DATA[7];
          bit_cnt  <= 3'd0;
          last_bit <= 1'b0;
          // The command wins. A bit-bang write in the same cycle is lost.
          ovr      <= bus.BB_WR;
        end else if (bus.BB_WR) begin
          sck  <= bus.BB_SCK;
          mosi <= bus.BB_MOSI;
          nss  <= bus.BB_NSS;
        end
      end else if (bus.CMD_STB || bus.BB_WR) begin
        ovr <= 1'b1;
      end

      if (enter_lead) begin
        sck   <= ~cpol;
        shreg <= {shreg[6:0], miso_sel};
      end

      if (enter_trail) begin
        sck <= cpol;
        // After the shift on the leading edge, shreg[7] holds the next TX bit.
        if (bit_cnt != 3'd7) begin
          mosi    <= shreg[7];
          bit_cnt <= bit_cnt + 3'd1;
        end else begin
          last_bit <= 1'b1;
        end
      end

      if (state_nxt == FIN) rxdata <= shreg;
    end
  end

  assign bus.SCK    = sck;
  assign bus.MOSI   = mosi;
  assign bus.nSS    = nss;
  assign bus.RXDATA = rxdata;
  assign bus.OVR    = ovr;

endmodule

// File: tb/tb_spi_byte_engine.sv
// tb_spi_byte_engine
//   Randomized bench for spi_byte_engine. Instance dut_a uses CLKDIV=2 and
//   instance dut_b uses CLKDIV=1. A slave model drives MISO one bit per
//   leading SCK edge. Each transfer is checked against byte-level expectations
//   (the TX bits seen on MOSI, the RX byte from the selected lines, cycle
//   counts and the OVR rules).
module tb_spi_byte_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       stb, bb_wr, bb_sck, bb_mosi, cmd_cpol;
  logic [1:0] bb_nss, cmd_nss;
  logic [7:0] cmd_data;
  logic [2:0] miso;
  logic       sel;

  int         chk_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] last_rx;

  always #5 clk = ~clk;

  spi_byte_engine_if ifa ();
  spi_byte_engine_if ifb ();

  assign ifa.CMD_STB  = stb & ~sel;
  assign ifb.CMD_STB  = stb & sel;
  assign ifa.BB_WR    = bb_wr & ~sel;
  assign ifb.BB_WR    = bb_wr & sel;
  assign ifa.CMD_DATA = cmd_data;
  assign ifb.CMD_DATA = cmd_data;
  assign ifa.CMD_NSS  = cmd_nss;
  assign ifb.CMD_NSS  = cmd_nss;
  assign ifa.CMD_CPOL = cmd_cpol;
  assign ifb.CMD_CPOL = cmd_cpol;
  assign ifa.BB_SCK   = bb_sck;
  assign ifb.BB_SCK   = bb_sck;
  assign ifa.BB_MOSI  = bb_mosi;
  assign ifb.BB_MOSI  = bb_mosi;
  assign ifa.BB_NSS   = bb_nss;
  assign ifb.BB_NSS   = bb_nss;
  assign ifa.MISO     = miso;
  assign ifb.MISO     = miso;

  spi_byte_engine #(.CLKDIV(2)) dut_a (.CLK(clk), .RST(rst), .bus(ifa));
  spi_byte_engine #(.CLKDIV(1)) dut_b (.CLK(clk), .RST(rst), .bus(ifb));

  logic       o_sck, o_mosi, o_busy, o_done, o_ovr;
  logic [1:0] o_nss;
  logic [7:0] o_rx;

  assign o_sck  = sel ? ifb.SCK    : ifa.SCK;
  assign o_mosi = sel ? ifb.MOSI   : ifa.MOSI;
  assign o_busy = sel ? ifb.BUSY   : ifa.BUSY;
  assign o_done = sel ? ifb.DONE   : ifa.DONE;
  assign o_ovr  = sel ? ifb.OVR    : ifa.OVR;
  assign o_nss  = sel ? ifb.nSS    : ifa.nSS;
  assign o_rx   = sel ? ifb.RXDATA : ifa.RXDATA;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Call this at a falling edge. It returns at the falling edge where BUSY is
  // first seen low, which is the cycle a back-to-back command may be issued.
  task automatic xfer(input logic [7:0] d, input logic [1:0] nss, input logic cpol,
                      input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] m2,
                      input int inj, input int rst_at, input logic bb_same);
    logic [7:0] got, rx_exp;
    int         lead, edges, bcyc, dcnt, cyc, div;
    logic       prev, ovr_exp;
    div     = sel ? 1 : 2;
    rx_exp  = (nss[0] ? 8'h00 : m0) | (nss[1] ? 8'h00 : m1) | ((nss == 2'b11) ? m2 : 8'h00);
    ovr_exp = bb_same || (inj > 0);
    got = 8'h00; lead = 0; edges = 0; bcyc = 0; dcnt = 0;
    cmd_data = d; cmd_nss = nss; cmd_cpol = cpol; stb = 1'b1;
    miso = {m2[7], m1[7], m0[7]};
    if (bb_same) begin
      bb_wr = 1'b1; bb_nss = ~nss; bb_sck = ~cpol; bb_mosi = ~d[7];
    end
    @(negedge clk);
    stb = 1'b0; bb_wr = 1'b0;
    // The command fields are sampled once, so scrambling them now must not matter.
    cmd_data = 8'($urandom); cmd_nss = 2'($urandom); cmd_cpol = 1'($urandom);
    check("idle_sck", o_sck, cpol);
    check("xfer_nss", o_nss, nss);
    prev = o_sck;
    cyc = 1;
    while (o_busy && cyc < 200) begin
      bcyc++;
      if (o_done) dcnt++;
      if (o_sck !== prev) begin
        edges++;
        if (o_sck !== cpol) begin
          got = {got[6:0], o_mosi};
          lead++;
          if (lead < 8) miso = {m2[7-lead], m1[7-lead], m0[7-lead]};
        end
        prev = o_sck;
      end
      if (cyc == inj) begin
        stb = 1'b1; bb_wr = 1'b1;
        cmd_data = 8'($urandom); cmd_nss = 2'($urandom); cmd_cpol = 1'($urandom);
        bb_nss = 2'($urandom); bb_sck = 1'($urandom); bb_mosi = 1'($urandom);
      end
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_nss", o_nss, 2'b11);
        check("rst_sck", o_sck, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_rx", o_rx, 8'h00);
        check("rst_ovr", o_ovr, 1'b0);
        check("rst_nodone", dcnt, 0);
        last_rx = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      stb = 1'b0; bb_wr = 1'b0;
      cyc++;
    end
    check("timeout", o_busy, 1'b0);
    check("busy_len", bcyc, 17 * div + 1);
    check("done_cnt", dcnt, 1);
    check("sck_edges", edges, 16);
    check("mosi_bits", got, d);
    check("rxdata", o_rx, rx_exp);
    check("nss_hold", o_nss, nss);
    check("sck_end", o_sck, cpol);
    check("mosi_end", o_mosi, d[0]);
    check("ovr", o_ovr, ovr_exp);
    check("done_low", o_done, 1'b0);
    last_rx = rx_exp;
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; bb_wr = 1'b0; bb_sck = 1'b0; bb_mosi = 1'b0;
    bb_nss = 2'b11; cmd_nss = 2'b11; cmd_data = 8'h00; cmd_cpol = 1'b0;
    miso = 3'b000; sel = 1'b0; last_rx = 8'h00;
    repeat (2) @(negedge clk);
    check("r_sck", o_sck, 1'b0);
    check("r_mosi", o_mosi, 1'b0);
    check("r_nss", o_nss, 2'b11);
    check("r_busy", o_busy, 1'b0);
    check("r_done", o_done, 1'b0);
    check("r_rx", o_rx, 8'h00);
    check("r_ovr", o_ovr, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    xfer(8'hA5, 2'b10, 1'b0, 8'h3C, 8'($urandom), 8'($urandom), -1, -1, 1'b0);
    xfer(8'hFF, 2'b11, 1'b1, 8'($urandom), 8'($urandom), 8'hFF, -1, -1, 1'b0);
    xfer(8'($urandom), 2'b01, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 10, -1, 1'b0);
    xfer(8'($urandom), 2'b10, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), -1, -1, 1'b0);

    @(negedge clk);
    bb_wr = 1'b1; bb_nss = 2'b11; bb_sck = 1'b1; bb_mosi = 1'b1;
    @(negedge clk);
    bb_wr = 1'b0;
    check("bb_sck", o_sck, 1'b1);
    check("bb_mosi", o_mosi, 1'b1);
    check("bb_nss", o_nss, 2'b11);
    check("bb_ovr", o_ovr, 1'b0);
    check("bb_rx", o_rx, last_rx);
    bb_wr = 1'b1; bb_nss = 2'b01; bb_sck = 1'b0; bb_mosi = 1'b0;
    @(negedge clk);
    bb_wr = 1'b0;
    check("bb2_sck", o_sck, 1'b0);
    check("bb2_mosi", o_mosi, 1'b0);
    check("bb2_nss", o_nss, 2'b01);
    check("bb2_busy", o_busy, 1'b0);

    xfer(8'($urandom), 2'b10, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), -1, -1, 1'b1);

    @(negedge clk);
    xfer(8'($urandom), 2'b10, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), -1, 20, 1'b0);
    xfer(8'($urandom), 2'b01, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), -1, -1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      xfer(8'($urandom), 2'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
           8'($urandom), -1, -1, 1'b0);
    end

    sel = 1'b1;
    @(negedge clk);
    xfer(8'($urandom), 2'b10, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), -1, -1, 1'b0);
    xfer(8'($urandom), 2'b10, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), -1, -1, 1'b0);
    xfer(8'($urandom), 2'b11, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/spi_byte_engine.md
Name: spi_byte_engine

Overview:
- Hardware SPI byte shifter that takes over sequencing of the expansion SPI port (SCK, MOSI, nSS[1:0], MISO[2:0]) from the ctrl-code bit-bang path.
- Sits beside the ctrl decode. A one-cycle command strobe starts an 8-bit MSB-first full-duplex transfer.
- Arbitrates port ownership between the engine and bit-bang writes.
- Received byte and status are exported for the GBUS read mux.

Parameters:
- CLKDIV, 2, SCK half-period in CLK cycles; legal range 1..255; divider counter is 8 bits wide.

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous reset, active-high
- CMD_STB  input  1  one-cycle pulse: start transfer
- CMD_DATA  input  8  byte to transmit, MSB first
- CMD_NSS  input  2  active-low slave selects to drive for this transfer
- CMD_CPOL  input  1  SCK idle level for this transfer (CPHA fixed at 0)
- BB_WR  input  1  one-cycle pulse: bit-bang write
- BB_SCK, BB_MOSI  input  1 each  bit-bang values
- BB_NSS  input  2  bit-bang slave selects
- MISO  input  3  slave data lines
- SCK, MOSI  output  1 each  SPI clock and data
- nSS  output  2  slave selects, active-low
- BUSY  output  1  transfer in progress
- DONE  output  1  one-cycle pulse at transfer end
- RXDATA  output  8  last received byte
- OVR  output  1  sticky flag: command or bit-bang write lost

Behaviour:
- Reset (async, immediate, including mid-transfer): SCK=0, MOSI=0, nSS=2'b11, BUSY=0, DONE=0, RXDATA=0, OVR=0, state IDLE. Any partial byte is discarded.
- MISO select, registered at sample time: MISO[0]&!nSS[0] | MISO[1]&!nSS[1] | MISO[2]&nSS[0]&nSS[1].
- States: IDLE, SETUP, LEAD, TRAIL, FIN.
- IDLE, CMD_STB=1 (cycle 0):
  - latch shift register <= CMD_DATA, CPOL <= CMD_CPOL;
  - nSS <= CMD_NSS, SCK <= CMD_CPOL, MOSI <= CMD_DATA[7];
  - clear bit counter and OVR;
  - go SETUP. BUSY reads 1 from cycle 1.
- SETUP: hold CLKDIV cycles, then go LEAD.
- Entering LEAD: SCK <= !CPOL, sample MISO into shift LSB (shift left). Hold CLKDIV cycles, then go TRAIL.
- Entering TRAIL: SCK <= CPOL.
  - bit counter < 7: MOSI <= next bit, counter++, hold CLKDIV cycles, then go LEAD.
  - bit counter = 7: hold CLKDIV cycles, then go FIN.
- FIN (exactly one cycle): RXDATA <= shift register, DONE=1, BUSY still 1. Next cycle: IDLE, BUSY=0, DONE=0.
- Total BUSY duration: 17*CLKDIV+1 cycles; 35 cycles at CLKDIV=2.
- SCK toggles exactly 16 times per transfer and ends at CPOL.
- nSS stays at CMD_NSS after the transfer. Multi-byte frames keep the slave selected. Deselect requires a command or bit-bang write with nSS=2'b11.
- MOSI holds the last transmitted bit after FIN.
- BB_WR in IDLE: SCK, MOSI, nSS <= BB_* on the next edge. RXDATA is unaffected.
- Lost writes set OVR=1, with no other effect:
  - BB_WR or CMD_STB while BUSY (including the FIN cycle);
  - BB_WR in the same IDLE cycle as CMD_STB (the command wins).
- OVR clears only on reset or on the next accepted CMD_STB.
- CMD_DATA, CMD_NSS and CMD_CPOL are sampled only in the accepting cycle; later changes have no effect.

Test Plan:
- Reset, then CMD_STB with CMD_DATA=0xA5, CMD_NSS=2'b10, CPOL=0, MISO[0] driven with 0x3C MSB-first on rising SCK:
  - MOSI bits on rising SCK read 1,0,1,0,0,1,0,1;
  - 16 SCK edges; BUSY high for 35 cycles;
  - DONE pulses once; RXDATA=0x3C; nSS stays 2'b10.
- CPOL=1, CMD_DATA=0xFF, MISO[2]=1, CMD_NSS=2'b11: SCK idles 1 and first edge falls; RXDATA=0xFF; SCK ends at 1.
- CMD_STB and BB_WR mid-transfer (cycle 10): transfer completes unchanged and OVR=1. Next accepted command clears OVR.
- Idle BB_WR with BB_NSS=2'b11, BB_SCK=1, BB_MOSI=1: outputs follow next cycle. Simultaneous CMD_STB+BB_WR: command starts with its own nSS, and OVR=1.
- RST asserted at cycle 20 of a transfer: nSS=2'b11, SCK=0, BUSY=0 immediately, with no DONE pulse and RXDATA=0. A new command afterwards completes normally.
- CLKDIV=1 build: back-to-back commands, the second issued in the cycle BUSY falls. Each BUSY period lasts 18 cycles, and both RXDATA values are correct.
